// File: rtl/dma_arbiter_if.sv
// Signal bundle between dma_arbiter, its requesters and the shared dma_controller.
// slave = the arbiter; master = the requesters together with the controller's done line.
interface dma_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 4,
    parameter int SIZE_W  = 5
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*SIZE_W-1:0] req_size;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        cmp;
    logic [NUM_REQ-1:0]        err;
    logic                      busy;
    logic                      dma_start;
    logic [ADDR_W-1:0]         dma_start_address;
    logic [SIZE_W-1:0]         dma_transfer_size;
    logic                      dma_done;

    modport slave (
        input  req, req_addr, req_size, dma_done,
        output grant, cmp, err, busy, dma_start, dma_start_address, dma_transfer_size
    );

    modport master (
        output req, req_addr, req_size, dma_done,
        input  grant, cmp, err, busy, dma_start, dma_start_address, dma_transfer_size
    );
endinterface

// File: rtl/dma_arbiter.sv
// Round-robin arbiter sharing one dma_controller between NUM_REQ requesters,
// with job validation and a BUSY watchdog.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  S_IDLE   | waiting for any req; picks winner, latches its job
//  S_CHECK  | validates size/range of the latched job
//  S_LAUNCH | dma_start pulse, address/size presented to controller
//  S_ARM    | one cycle where a stale dma_done from the last job is ignored
//  S_BUSY   | waiting for dma_done, watchdog running
//  S_DONE   | cmp/err pulse to owner, grant released on exit
module dma_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_W    = 4,
    parameter int SIZE_W    = 5,
    parameter int MEM_DEPTH = 16,
    parameter int TIMEOUT   = 255
) (
    input logic          clk,
    input logic          rst,
    dma_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SUM_W = ((ADDR_W > SIZE_W) ? ADDR_W : SIZE_W) + 1;
    localparam int WD_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_LAUNCH,
        S_ARM,
        S_BUSY,
        S_DONE
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  job_idx;
    logic [ADDR_W-1:0] job_addr;
    logic [SIZE_W-1:0] job_size;
    logic [WD_W-1:0]   watchdog;

    logic [IDX_W-1:0]  win_idx;
    logic [IDX_W-1:0]  hi_idx;
    logic [IDX_W-1:0]  lo_idx;
    logic              hi_found;
    logic              lo_found;
    logic              win_found;
    logic [ADDR_W-1:0] sel_addr;
    logic [SIZE_W-1:0] sel_size;
    logic [SUM_W-1:0]  job_end;
    logic              job_bad;
    logic [WD_W-1:0]   wd_next;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    // Lowest requester above rr_ptr wins; otherwise wrap to the lowest at or below it.
    always_comb begin
        hi_idx   = '0;
        lo_idx   = '0;
        hi_found = 1'b0;
        lo_found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                if (IDX_W'(i) > rr_ptr) begin
                    hi_idx   = IDX_W'(i);
                    hi_found = 1'b1;
                end else begin
                    lo_idx   = IDX_W'(i);
                    lo_found = 1'b1;
                end
            end
        end
        win_idx   = hi_found ? hi_idx : lo_idx;
        win_found = hi_found | lo_found;
    end

    always_comb begin
        sel_addr = '0;
        sel_size = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == win_idx) begin
                sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_size = bus.req_size[i*SIZE_W +: SIZE_W];
            end
        end
    end

    // Sum is one bit wider than either operand so an out-of-range job cannot wrap to look valid.
    always_comb begin
        job_end = SUM_W'(job_addr) + SUM_W'(job_size);
        job_bad = (job_size == '0) || (job_end > SUM_W'(MEM_DEPTH));
        wd_next = watchdog + WD_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= S_IDLE;
            rr_ptr                <= IDX_W'(NUM_REQ - 1);
            job_idx               <= '0;
            job_addr              <= '0;
            job_size              <= '0;
            watchdog              <= '0;
            bus.grant             <= '0;
            bus.cmp               <= '0;
            bus.err               <= '0;
            bus.busy              <= 1'b0;
            bus.dma_start         <= 1'b0;
            bus.dma_start_address <= '0;
            bus.dma_transfer_size <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        job_idx   <= win_idx;
                        job_addr  <= sel_addr;
                        job_size  <= sel_size;
                        rr_ptr    <= win_idx;
                        bus.grant <= onehot(win_idx);
                        bus.busy  <= 1'b1;
                        state     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (job_bad) begin
                        bus.cmp <= onehot(job_idx);
                        bus.err <= onehot(job_idx);
                        state   <= S_DONE;
                    end else begin
                        bus.dma_start         <= 1'b1;
                        bus.dma_start_address <= job_addr;
                        bus.dma_transfer_size <= job_size;
                        state                 <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    bus.dma_start <= 1'b0;
                    state         <= S_ARM;
                end
                S_ARM: begin
                    watchdog <= '0;
                    state    <= S_BUSY;
                end
                S_BUSY: begin
                    watchdog <= wd_next;
                    if (bus.dma_done) begin
                        bus.cmp <= onehot(job_idx);
                        bus.err <= '0;
                        state   <= S_DONE;
                    end else if (wd_next == WD_W'(TIMEOUT)) begin
                        bus.cmp <= onehot(job_idx);
                        bus.err <= onehot(job_idx);
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    bus.cmp   <= '0;
                    bus.err   <= '0;
                    bus.grant <= '0;
                    bus.busy  <= 1'b0;
                    watchdog  <= '0;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
